// File: rtl/ili9341_stream.sv
`default_nettype none
// ============================================================================
//  Module   : ili9341_stream
//  Purpose  : Autonomous RGB565 pixel streamer for the ILI9341 8080-style
//             8-bit write bus. On each frame start it issues the window
//             setup sequence (CASET/PASET/RAMWR). It then drains a pixel
//             FIFO as hi/lo byte pairs.
//  Options  : ILI9341_STREAM_STATS_EN adds the underruns and fifo_level ports.
//  Revision : 1.0 - initial release
// ============================================================================
module ili9341_stream #(
    parameter int FIFO_DEPTH = 16,
    parameter int WR_HALF    = 1,
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic        pix_ready,
    output logic        busy,
    output logic        frame_done,
`ifdef ILI9341_STREAM_STATS_EN
    output logic [15:0] underruns,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
`endif
    output logic        cmd_data,
    output logic        write_edge,
    output logic [7:0]  dout
);

    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam int              HW        = (WR_HALF > 1) ? $clog2(WR_HALF) : 1;
    localparam logic [16:0]     TOTAL     = 17'(WIDTH * HEIGHT);
    localparam logic [15:0]     W_M1      = 16'(WIDTH - 1);
    localparam logic [15:0]     H_M1      = 16'(HEIGHT - 1);
    localparam logic [HW-1:0]   HALF_LAST = HW'(WR_HALF - 1);
    localparam logic [AW:0]     DEPTH_C   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [3:0]      HDR_LEN   = 4'd11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_PIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          armed_q, armed_d;
    logic [16:0]   acc_cnt_q, acc_cnt_d;
    logic [16:0]   emit_cnt_q, emit_cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [15:0]   mem_d [FIFO_DEPTH];
    logic          active_q, active_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [3:0]    hdr_idx_q, hdr_idx_d;
    logic          lo_pend_q, lo_pend_d;
    logic [7:0]    lo_byte_q, lo_byte_d;
    logic          we_q, we_d;
    logic          cd_q, cd_d;
    logic [7:0]    dout_q, dout_d;

    logic w_start, w_full, w_empty, w_push, w_pop;
    logic w_last_cycle, w_free, w_pix_slot;
    logic [8:0] w_hdr;

    // Header byte table: {cmd_data, byte}; commands carry cmd_data = 0.
    function automatic logic [8:0] hdr_byte(input logic [3:0] idx);
        case (idx)
            4'd0:    hdr_byte = {1'b0, 8'h2A};
            4'd3:    hdr_byte = {1'b1, W_M1[15:8]};
            4'd4:    hdr_byte = {1'b1, W_M1[7:0]};
            4'd5:    hdr_byte = {1'b0, 8'h2B};
            4'd8:    hdr_byte = {1'b1, H_M1[15:8]};
            4'd9:    hdr_byte = {1'b1, H_M1[7:0]};
            4'd10:   hdr_byte = {1'b0, 8'h2C};
            default: hdr_byte = {1'b1, 8'h00};
        endcase
    endfunction

    assign w_start      = (state_q == S_IDLE) && frame_start;
    assign w_full       = (count_q == DEPTH_C);
    assign w_empty      = (count_q == '0);
    assign pix_ready    = armed_q && !w_full;
    assign w_push       = pix_valid && pix_ready;
    // A byte ends on the last cycle of its high phase; the next byte loads then.
    assign w_last_cycle = active_q && we_q && (hcnt_q == HALF_LAST);
    assign w_free       = !active_q || w_last_cycle;
    assign w_hdr        = hdr_byte(hdr_idx_q);

    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_DONE);
    assign cmd_data   = cd_q;
    assign write_edge = we_q;
    assign dout       = dout_q;

    // Input side: arming, accept counter and FIFO write/read bookkeeping.
    always_comb begin
        armed_d   = armed_q;
        acc_cnt_d = acc_cnt_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        mem_d     = mem_q;
        if (w_start) begin
            armed_d   = 1'b1;
            acc_cnt_d = '0;
        end else if (w_push) begin
            acc_cnt_d = acc_cnt_q + 17'd1;
            if (acc_cnt_q == TOTAL - 17'd1) begin
                armed_d = 1'b0;
            end
        end
        if (w_push) begin
            mem_d[wr_ptr_q] = pix_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
    end

    // Sequencer and byte engine: strobe phasing, header walk, pixel drain.
    always_comb begin
        state_d    = state_q;
        emit_cnt_d = emit_cnt_q;
        active_d   = active_q;
        hcnt_d     = hcnt_q;
        hdr_idx_d  = hdr_idx_q;
        lo_pend_d  = lo_pend_q;
        lo_byte_d  = lo_byte_q;
        we_d       = we_q;
        cd_d       = cd_q;
        dout_d     = dout_q;
        w_pop      = 1'b0;
        w_pix_slot = 1'b0;

        if (active_q && !w_last_cycle) begin
            if (hcnt_q == HALF_LAST) begin
                we_d   = 1'b1;
                hcnt_d = '0;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d    = S_HDR;
                    hdr_idx_d  = '0;
                    emit_cnt_d = '0;
                    lo_pend_d  = 1'b0;
                end
            end
            S_HDR: begin
                if (w_free) begin
                    if (hdr_idx_q != HDR_LEN) begin
                        {cd_d, dout_d} = w_hdr;
                        we_d      = 1'b0;
                        hcnt_d    = '0;
                        active_d  = 1'b1;
                        hdr_idx_d = hdr_idx_q + 4'd1;
                    end else begin
                        // Hand over to pixel drain without a bubble cycle.
                        state_d    = S_PIX;
                        w_pix_slot = 1'b1;
                    end
                end
            end
            S_PIX: begin
                w_pix_slot = w_free;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_pix_slot) begin
            if (lo_pend_q) begin
                dout_d    = lo_byte_q;
                cd_d      = 1'b1;
                we_d      = 1'b0;
                hcnt_d    = '0;
                active_d  = 1'b1;
                lo_pend_d = 1'b0;
            end else if (emit_cnt_q == TOTAL) begin
                state_d  = S_DONE;
                active_d = 1'b0;
                we_d     = 1'b0;
            end else if (!w_empty) begin
                w_pop      = 1'b1;
                dout_d     = mem_q[rd_ptr_q][15:8];
                lo_byte_d  = mem_q[rd_ptr_q][7:0];
                cd_d       = 1'b1;
                we_d       = 1'b0;
                hcnt_d     = '0;
                active_d   = 1'b1;
                lo_pend_d  = 1'b1;
                emit_cnt_d = emit_cnt_q + 17'd1;
            end else begin
                // Starved: park the strobe low until a pixel arrives.
                active_d = 1'b0;
                we_d     = 1'b0;
            end
        end
    end

    // State registers; reset aborts any byte in flight.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            armed_q    <= 1'b0;
            acc_cnt_q  <= '0;
            emit_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            active_q   <= 1'b0;
            hcnt_q     <= '0;
            hdr_idx_q  <= '0;
            lo_pend_q  <= 1'b0;
            lo_byte_q  <= '0;
            we_q       <= 1'b0;
            cd_q       <= 1'b1;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            acc_cnt_q  <= acc_cnt_d;
            emit_cnt_q <= emit_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            active_q   <= active_d;
            hcnt_q     <= hcnt_d;
            hdr_idx_q  <= hdr_idx_d;
            lo_pend_q  <= lo_pend_d;
            lo_byte_q  <= lo_byte_d;
            we_q       <= we_d;
            cd_q       <= cd_d;
            dout_q     <= dout_d;
        end
    end

    // Pixel storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef ILI9341_STREAM_STATS_EN
    logic [15:0] under_q, under_d;
    logic        w_stall;

    assign w_stall    = (state_q == S_PIX) && w_free && !lo_pend_q &&
                        (emit_cnt_q != TOTAL) && w_empty;
    assign underruns  = under_q;
    assign fifo_level = count_q;

    // Saturating starvation counter, cleared when a frame is armed.
    always_comb begin
        under_d = under_q;
        if (w_start) begin
            under_d = '0;
        end else if (w_stall && (under_q != 16'hFFFF)) begin
            under_d = under_q + 16'd1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            under_q <= '0;
        end else begin
            under_q <= under_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ili9341_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ili9341_stream
//  Purpose  : Scoreboard bench for ili9341_stream. Two instances are used:
//             A (FIFO 16, WR_HALF 1) and B (FIFO 4, WR_HALF 4), both 4x2.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ili9341_stream;

    typedef struct packed {
        logic       cd;
        logic [7:0] b;
        logic [3:0] hidx;   // header position, 15 for pixel bytes
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn;
    logic a_fs, a_pv, a_pr, a_busy, a_done, a_cd, a_we;
    logic [15:0] a_pd;
    logic [7:0]  a_dout;
    logic b_fs, b_pv, b_pr, b_busy, b_done, b_cd, b_we;
    logic [15:0] b_pd;
    logic [7:0]  b_dout;
`ifdef ILI9341_STREAM_STATS_EN
    logic [15:0] a_und, b_und;
    logic [4:0]  a_lvl;
    logic [2:0]  b_lvl;
`endif

    ili9341_stream #(.FIFO_DEPTH(16), .WR_HALF(1), .WIDTH(4), .HEIGHT(2)) dut_a (
        .clk(clk), .resetn(resetn), .frame_start(a_fs), .pix_valid(a_pv),
        .pix_data(a_pd), .pix_ready(a_pr), .busy(a_busy), .frame_done(a_done),
`ifdef ILI9341_STREAM_STATS_EN
        .underruns(a_und), .fifo_level(a_lvl),
`endif
        .cmd_data(a_cd), .write_edge(a_we), .dout(a_dout));

    ili9341_stream #(.FIFO_DEPTH(4), .WR_HALF(4), .WIDTH(4), .HEIGHT(2)) dut_b (
        .clk(clk), .resetn(resetn), .frame_start(b_fs), .pix_valid(b_pv),
        .pix_data(b_pd), .pix_ready(b_pr), .busy(b_busy), .frame_done(b_done),
`ifdef ILI9341_STREAM_STATS_EN
        .underruns(b_und), .fifo_level(b_lvl),
`endif
        .cmd_data(b_cd), .write_edge(b_we), .dout(b_dout));

    // Expected header for a 4x2 window.
    logic [7:0] hdr_b  [11] = '{8'h2A, 8'h00, 8'h00, 8'h00, 8'h03,
                                8'h2B, 8'h00, 8'h00, 8'h00, 8'h01, 8'h2C};
    logic       hdr_cd [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                                1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    exp_t qa[$];
    exp_t qb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   a_strobes = 0, b_strobes = 0, a_done_cnt = 0, b_done_cnt = 0;
    int   a_last_edge = 0;
    logic a_we_prev = 1'b0, b_we_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor A: every rising write_edge pops and compares one expected byte.
    always @(negedge clk) begin
        exp_t e;
        if (a_we && !a_we_prev) begin
            a_strobes++;
            if (qa.size() == 0) begin
                chk("a_unexpected_strobe", {23'd0, a_cd, a_dout}, 32'hFFFFFFFF);
            end else begin
                e = qa.pop_front();
                chk("a_byte", {23'd0, a_cd, a_dout}, {23'd0, e.cd, e.b});
                if (e.hidx != 4'd0 && e.hidx != 4'd15)
                    chk("a_hdr_spacing", cyc - a_last_edge, 2);
            end
            a_last_edge = cyc;
        end
        a_we_prev = a_we;
        if (a_done) a_done_cnt++;
    end

    // Monitor B: same byte scoreboard for the slow, shallow instance.
    always @(negedge clk) begin
        exp_t e;
        if (b_we && !b_we_prev) begin
            b_strobes++;
            if (qb.size() == 0) begin
                chk("b_unexpected_strobe", {23'd0, b_cd, b_dout}, 32'hFFFFFFFF);
            end else begin
                e = qb.pop_front();
                chk("b_byte", {23'd0, b_cd, b_dout}, {23'd0, e.cd, e.b});
            end
        end
        b_we_prev = b_we;
        if (b_done) b_done_cnt++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_hdr(input bit sel);
        for (int i = 0; i < 11; i++) begin
            if (sel) qb.push_back({hdr_cd[i], hdr_b[i], 4'(i)});
            else     qa.push_back({hdr_cd[i], hdr_b[i], 4'(i)});
        end
    endtask

    // Pulse frame_start on A while idle; the header becomes expected.
    task automatic start_a();
        step();
        a_fs = 1'b1;
        push_hdr(1'b0);
        step();
        a_fs = 1'b0;
    endtask

    // Stream n pixels into A with pix_valid held; expected bytes queued on accept.
    task automatic send_a(input logic [15:0] base, input logic [15:0] stride,
                          input int first, input int n);
        int i = first;
        int t = 0;
        while (i < first + n && t < 2000) begin
            a_pv = 1'b1;
            a_pd = base + 16'(i) * stride;
            if (a_pr) begin
                qa.push_back({1'b1, a_pd[15:8], 4'hF});
                qa.push_back({1'b1, a_pd[7:0], 4'hF});
                i++;
            end
            step();
            t++;
        end
        a_pv = 1'b0;
        chk("a_send_timeout", (t < 2000), 1);
    endtask

    task automatic wait_done_a(input int start_cnt);
        int t = 0;
        while (a_done_cnt == start_cnt && t < 3000) begin
            step();
            t++;
        end
        chk("a_done_timeout", (a_done_cnt != start_cnt), 1);
        step();
        chk("a_busy_after_done", a_busy, 0);
        chk("a_queue_drained", qa.size(), 0);
    endtask

    initial begin
        int d0, s0, t, hi_cnt, drop_at;
        resetn = 1'b0;
        a_fs = 0; a_pv = 0; a_pd = '0;
        b_fs = 0; b_pv = 0; b_pd = '0;
        repeat (3) step();

        // Reset values.
        chk("rst_write_edge", a_we, 0);
        chk("rst_cmd_data", a_cd, 1);
        chk("rst_dout", a_dout, 0);
        chk("rst_pix_ready", a_pr, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_frame_done", a_done, 0);
        resetn = 1'b1;
        step();

        // Frame 1: header plus 8 pixels 0x1234..0x123B, pix_valid held high.
        d0 = a_done_cnt;
        start_a();
        chk("a_busy_rises", a_busy, 1);
        send_a(16'h1234, 16'h0001, 0, 8);
        chk("a_ready_low_after_last", a_pr, 0);
        wait_done_a(d0);
        repeat (20) step();
        chk("a_single_done_f1", a_done_cnt - d0, 1);

        // Frame 2: pixel 3 withheld until the FIFO runs dry; re-pulse frame_start in PIX.
        d0 = a_done_cnt;
        s0 = a_strobes;
        start_a();
        send_a(16'hA5C3, 16'h0101, 0, 3);
        t = 0;
        while (a_strobes < s0 + 17 && t < 2000) begin
            step();
            t++;
        end
        chk("a_gap_wait_timeout", (t < 2000), 1);
        hi_cnt = 0;
        for (int k = 0; k < 18; k++) begin
            step();
            a_fs = (k == 0);
            if (a_we) hi_cnt++;
        end
        a_fs = 1'b0;
        chk("a_gap_no_strobe", hi_cnt, 0);
        chk("a_busy_in_gap", a_busy, 1);
        send_a(16'hA5C3, 16'h0101, 3, 5);
        wait_done_a(d0);
`ifdef ILI9341_STREAM_STATS_EN
        chk("a_underruns_range", (a_und >= 16'd18 && a_und <= 16'd20), 1);
`endif
        repeat (20) step();
        chk("a_single_done_f2", a_done_cnt - d0, 1);

        // Reset mid-header aborts; a new frame replays the full header.
        start_a();
        repeat (6) step();
        resetn = 1'b0;
        qa.delete();
        step();
        resetn = 1'b1;
        chk("a_rst_write_edge", a_we, 0);
        chk("a_rst_busy", a_busy, 0);
        chk("a_rst_pix_ready", a_pr, 0);
        repeat (3) step();
        d0 = a_done_cnt;
        start_a();
        send_a(16'h0F00, 16'h0011, 0, 8);
        wait_done_a(d0);

        // Instance B: shallow FIFO, slow strobe; pix_ready must drop at 4 queued.
        d0 = b_done_cnt;
        step();
        b_fs = 1'b1;
        push_hdr(1'b1);
        step();
        b_fs = 1'b0;
        begin
            int i = 0;
            drop_at = -1;
            t = 0;
            while (i < 8 && t < 3000) begin
                b_pv = 1'b1;
                b_pd = 16'hC000 + 16'(i) * 16'h0203;
                if (b_pr) begin
                    qb.push_back({1'b1, b_pd[15:8], 4'hF});
                    qb.push_back({1'b1, b_pd[7:0], 4'hF});
                    i++;
                end else if (drop_at < 0) begin
                    drop_at = i;
                end
                step();
                t++;
            end
            b_pv = 1'b0;
            chk("b_send_timeout", (t < 3000), 1);
        end
        chk("b_ready_drop_at_4", drop_at, 4);
        t = 0;
        while (b_done_cnt == d0 && t < 3000) begin
            step();
            t++;
        end
        chk("b_done_timeout", (b_done_cnt != d0), 1);
        step();
        chk("b_busy_after_done", b_busy, 0);
        chk("b_queue_drained", qb.size(), 0);
        chk("b_strobe_total", b_strobes, 27);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
